// File: rtl/div_frec_multi.sv
// Multi-channel programmable tick / square-wave generator.
// Each channel has a shadowed divisor and mode, applied at its terminal count.
module div_frec_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 26,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(833_333),
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                i_Rst,
  input  logic                i_CE,
  input  logic [CHANNELS-1:0] i_ch_en,
  input  logic                i_wr,
  input  logic [CH_W-1:0]     i_wr_ch,
  input  logic [WIDTH-1:0]    i_wr_div,
  input  logic                i_wr_mode,
  output logic                o_wr_ack,
  output logic [CHANNELS-1:0] o_pend,
  output logic [CHANNELS-1:0] o_tick,
  output logic [CHANNELS-1:0] o_clk
);

  logic [WIDTH-1:0]    cnt    [CHANNELS];
  logic [WIDTH-1:0]    div_q  [CHANNELS];
  logic [WIDTH-1:0]    sh_div [CHANNELS];
  logic [CHANNELS-1:0] mode_q;
  logic [CHANNELS-1:0] sh_mode;
  logic [CHANNELS-1:0] pend_q;
  logic [CHANNELS-1:0] tick_q;
  logic [CHANNELS-1:0] clk_q;
  logic [CHANNELS-1:0] wr_hit;
  logic                ack_q;

  // Out-of-range channel indices simply match no channel.
  always_comb begin
    wr_hit = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      wr_hit[n] = i_wr && (i_wr_ch == CH_W'(n));
    end
  end

  always_ff @(posedge clk) begin
    if (i_Rst) begin
      for (int n = 0; n < CHANNELS; n++) begin
        cnt[n]    <= '0;
        div_q[n]  <= DEFAULT_DIV;
        sh_div[n] <= DEFAULT_DIV;
      end
      mode_q  <= '0;
      sh_mode <= '0;
      pend_q  <= '0;
      tick_q  <= '0;
      clk_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= i_wr;
      for (int n = 0; n < CHANNELS; n++) begin
        if (!i_ch_en[n]) begin
          cnt[n]    <= '0;
          tick_q[n] <= 1'b0;
          clk_q[n]  <= 1'b0;
          if (pend_q[n]) begin
            div_q[n]  <= sh_div[n];
            mode_q[n] <= sh_mode[n];
            pend_q[n] <= 1'b0;
          end
        end else if (i_CE) begin
          if (cnt[n] == div_q[n]) begin
            cnt[n]    <= '0;
            tick_q[n] <= 1'b1;
            if (pend_q[n]) begin
              div_q[n]  <= sh_div[n];
              mode_q[n] <= sh_mode[n];
              pend_q[n] <= 1'b0;
            end
            // A mode switch restarts the output low so no runt pulse appears.
            if (pend_q[n] && (sh_mode[n] != mode_q[n])) begin
              clk_q[n] <= 1'b0;
            end else if (mode_q[n]) begin
              clk_q[n] <= ~clk_q[n];
            end else begin
              clk_q[n] <= 1'b1;
            end
          end else begin
            cnt[n]    <= cnt[n] + WIDTH'(1);
            tick_q[n] <= 1'b0;
            if (!mode_q[n]) clk_q[n] <= 1'b0;
          end
        end else begin
          tick_q[n] <= 1'b0;
          if (!mode_q[n]) clk_q[n] <= 1'b0;
        end
        // A same-edge write lands after any apply and keeps pend set.
        if (wr_hit[n]) begin
          sh_div[n]  <= i_wr_div;
          sh_mode[n] <= i_wr_mode;
          pend_q[n]  <= 1'b1;
        end
      end
    end
  end

  assign o_wr_ack = ack_q;
  assign o_pend   = pend_q;
  assign o_tick   = tick_q;
  assign o_clk    = clk_q;

endmodule

// File: tb/tb_div_frec_multi.sv
// Directed bench for div_frec_multi (4 channels, 8-bit, default div 3).
// Inputs change 1 time unit after each rising edge; outputs sampled there.
module tb_div_frec_multi;

  logic       clk = 1'b0;
  logic       i_Rst;
  logic       i_CE;
  logic [3:0] i_ch_en;
  logic       i_wr;
  logic [1:0] i_wr_ch;
  logic [7:0] i_wr_div;
  logic       i_wr_mode;
  logic       o_wr_ack;
  logic [3:0] o_pend;
  logic [3:0] o_tick;
  logic [3:0] o_clk;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_frec_multi #(
    .CHANNELS(4),
    .WIDTH(8),
    .DEFAULT_DIV(8'd3)
  ) dut (
    .clk(clk),
    .i_Rst(i_Rst),
    .i_CE(i_CE),
    .i_ch_en(i_ch_en),
    .i_wr(i_wr),
    .i_wr_ch(i_wr_ch),
    .i_wr_div(i_wr_div),
    .i_wr_mode(i_wr_mode),
    .o_wr_ack(o_wr_ack),
    .o_pend(o_pend),
    .o_tick(o_tick),
    .o_clk(o_clk)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch,
                    input logic [7:0] dv,
                    input logic md);
    i_wr      = 1'b1;
    i_wr_ch   = ch;
    i_wr_div  = dv;
    i_wr_mode = md;
  endtask

  logic [3:0] et [4];
  logic [3:0] ec [4];

  initial begin
    i_Rst     = 1'b1;
    i_CE      = 1'b1;
    i_ch_en   = 4'hF;
    i_wr      = 1'b0;
    i_wr_ch   = '0;
    i_wr_div  = '0;
    i_wr_mode = 1'b0;

    // reset state
    step();
    step();
    chk("rst_tick", o_tick, 4'h0);
    chk("rst_clk", o_clk, 4'h0);
    chk("rst_pend", o_pend, 4'h0);
    chk("rst_ack", o_wr_ack, 1'b0);
    i_Rst = 1'b0;

    // default div 3: tick one cycle in four
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("p1_tick%0d", k), o_tick,
          (k % 4 == 0) ? 4'hF : 4'h0);
      chk($sformatf("p1_clk%0d", k), o_clk,
          (k % 4 == 0) ? 4'hF : 4'h0);
    end

    // ch1 -> div 1, square, written mid-period
    step();
    wr(2'd1, 8'd1, 1'b1);
    step();
    chk("p2_ack", o_wr_ack, 1'b1);
    chk("p2_pend", o_pend, 4'b0010);
    i_wr = 1'b0;
    step();
    chk("p2_ack_off", o_wr_ack, 1'b0);
    chk("p2_pend_hold", o_pend, 4'b0010);
    step();
    chk("p2_apply_tick", o_tick, 4'hF);
    chk("p2_apply_clk", o_clk, 4'b1101);
    chk("p2_apply_pend", o_pend, 4'h0);
    et = '{4'h0, 4'b0010, 4'h0, 4'hF};
    ec = '{4'h0, 4'b0010, 4'b0010, 4'b1101};
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("p2_sq_tick%0d", k), o_tick, et[k]);
      chk($sformatf("p2_sq_clk%0d", k), o_clk, ec[k]);
    end

    // ch2 write on its terminal-count cycle, then overwrite
    step();
    step();
    step();
    wr(2'd2, 8'd2, 1'b0);
    step();
    chk("p3_tc_tick", o_tick[2], 1'b1);
    chk("p3_ack1", o_wr_ack, 1'b1);
    chk("p3_pend1", o_pend, 4'b0100);
    wr(2'd2, 8'd5, 1'b0);
    step();
    chk("p3_ack2", o_wr_ack, 1'b1);
    chk("p3_pend2", o_pend, 4'b0100);
    i_wr = 1'b0;
    step();
    chk("p3_ack_off", o_wr_ack, 1'b0);
    step();
    chk("p3_pre_tick", o_tick[2], 1'b0);
    step();
    chk("p3_old_div_tick", o_tick[2], 1'b1);
    chk("p3_pend_clr", o_pend, 4'h0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("p3_gap%0d", k), o_tick[2], 1'b0);
    end
    step();
    chk("p3_div5_tick", o_tick[2], 1'b1);

    // 50 % clock enable: tick period doubles to 8
    i_Rst = 1'b1;
    step();
    i_Rst = 1'b0;
    chk("p4_rst_clk", o_clk, 4'h0);
    for (int k = 1; k <= 16; k++) begin
      i_CE = (k % 2 == 1);
      step();
      chk($sformatf("p4_tick%0d", k), o_tick[0],
          (k == 7 || k == 15));
      chk($sformatf("p4_clk%0d", k), o_clk[0],
          (k == 7 || k == 15));
    end

    // disable ch0, write div 0, re-enable
    i_CE = 1'b1;
    step();
    i_ch_en = 4'b1110;
    step();
    chk("p5_dis_clk", o_clk[0], 1'b0);
    chk("p5_dis_tick", o_tick[0], 1'b0);
    wr(2'd0, 8'd0, 1'b0);
    step();
    chk("p5_ack", o_wr_ack, 1'b1);
    chk("p5_pend", o_pend, 4'b0001);
    chk("p5_dis_clk2", o_clk[0], 1'b0);
    i_wr = 1'b0;
    step();
    chk("p5_applied", o_pend, 4'h0);
    i_ch_en = 4'hF;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("p5_tick%0d", k), o_tick[0], 1'b1);
      chk($sformatf("p5_clk%0d", k), o_clk[0], 1'b1);
    end

    // reset with a pending write and a write in flight
    wr(2'd3, 8'd7, 1'b1);
    step();
    chk("p6_pend", o_pend, 4'b1000);
    i_Rst = 1'b1;
    step();
    chk("p6_tick", o_tick, 4'h0);
    chk("p6_clk", o_clk, 4'h0);
    chk("p6_pend_clr", o_pend, 4'h0);
    chk("p6_ack", o_wr_ack, 1'b0);
    i_Rst = 1'b0;
    i_wr  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("p6_tick%0d", k), o_tick,
          (k == 4) ? 4'hF : 4'h0);
      chk($sformatf("p6_clk%0d", k), o_clk,
          (k == 4) ? 4'hF : 4'h0);
    end
    chk("p6_pend_end", o_pend, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
